// File: rtl/mor1kx_pcu_sampler_if.sv
// Snapshot stream between the PCU sampler FIFO and its trace/debug consumer.
//   snap_valid : FIFO head valid (source -> sink)
//   snap_ready : sink accepts head (sink -> source)
//   snap_data  : sampled PCCRn value
//   snap_idx   : counter index n
//   snap_last  : final entry of one sample
interface mor1kx_pcu_sampler_if;
  logic        snap_valid;
  logic        snap_ready;
  logic [31:0] snap_data;
  logic [2:0]  snap_idx;
  logic        snap_last;

  modport master (
    output snap_valid,
    output snap_data,
    output snap_idx,
    output snap_last,
    input  snap_ready
  );

  modport slave (
    input  snap_valid,
    input  snap_data,
    input  snap_idx,
    input  snap_last,
    output snap_ready
  );
endinterface

// File: rtl/mor1kx_pcu_sampler.sv
// Periodic snapshot controller for the performance counter unit.
// Every cfg_period_i+1 enabled idle cycles it reads the PCCRn registers
// selected by cfg_mask_i through the shared PCU SPR port and pushes
// {idx,last,value} into a first-word-fall-through FIFO that drains over
// the snap_if stream. The CPU always owns the PCU port when it accesses it.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cpu_spr_*              CPU side of the PCU SPR port
//   pcu_spr_*              PCU side of the SPR port (muxed CPU / sampler)
//   cfg_enable_i/period_i/mask_i   sampling configuration
//   snap_if                snapshot stream (master)
//   sample_done_o          pulse when the last entry of a sample is pushed
//   overflow_o/overflow_clr_i      sticky dropped-sample flag and its clear
//   busy_o                 scan in progress
module mor1kx_pcu_sampler #(
  parameter int unsigned OPTION_PERFCOUNTERS_NUM = 7,
  parameter int unsigned PERIOD_WIDTH            = 16,
  parameter int unsigned FIFO_DEPTH_LOG2         = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  // CPU SPR side
  input  logic                               cpu_spr_access_i,
  input  logic                               cpu_spr_we_i,
  input  logic                               cpu_spr_re_i,
  input  logic [15:0]                        cpu_spr_addr_i,
  input  logic [31:0]                        cpu_spr_dat_i,
  output logic                               cpu_spr_bus_ack_o,
  output logic [31:0]                        cpu_spr_dat_o,
  // PCU SPR side
  output logic                               pcu_spr_access_o,
  output logic                               pcu_spr_we_o,
  output logic                               pcu_spr_re_o,
  output logic [15:0]                        pcu_spr_addr_o,
  output logic [31:0]                        pcu_spr_dat_o,
  input  logic                               pcu_spr_bus_ack_i,
  input  logic [31:0]                        pcu_spr_dat_i,
  // configuration
  input  logic                               cfg_enable_i,
  input  logic [PERIOD_WIDTH-1:0]            cfg_period_i,
  input  logic [OPTION_PERFCOUNTERS_NUM:0]   cfg_mask_i,
  // snapshot stream and status
  mor1kx_pcu_sampler_if.master               snap_if,
  output logic                               sample_done_o,
  output logic                               overflow_o,
  input  logic                               overflow_clr_i,
  output logic                               busy_o
);

  localparam int unsigned MASK_W  = OPTION_PERFCOUNTERS_NUM + 1;
  localparam int unsigned DEPTH   = 32'd1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W   = FIFO_DEPTH_LOG2 + 1;
  // Wide enough for both the free-entry count and a popcount of up to 8.
  localparam int unsigned CMP_W   = (CNT_W > 4) ? CNT_W : 4;
  localparam int unsigned ENTRY_W = 3 + 1 + 32;

  localparam logic [15:0] PCCR0_ADDR = 16'h3800;
  localparam logic [2:0]  IDX_LAST   = 3'(OPTION_PERFCOUNTERS_NUM);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] count_q, count_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              mask_q, mask_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;

  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fill_q, fill_d;

  logic                    samp_access;
  logic                    push;
  logic                    pop;
  logic                    advance;
  logic                    drop;
  logic                    higher_set;
  logic                    fifo_valid;
  logic [CMP_W-1:0]        mask_pop;
  logic [CMP_W-1:0]        fifo_free;
  logic [ENTRY_W-1:0]      head;

  // State and status registers; rst mid-scan aborts and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // FIFO storage; occupancy tracking makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {idx_q, ~higher_set, pcu_spr_dat_i};
    end
  end

  // Next-state, scan control, FIFO bookkeeping and port mux.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    overflow_d  = overflow_q & ~overflow_clr_i;
    done_d      = 1'b0;
    samp_access = 1'b0;
    push        = 1'b0;
    advance     = 1'b0;
    drop        = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;

    mask_pop = '0;
    for (int unsigned j = 0; j < MASK_W; j++) begin
      mask_pop = mask_pop + CMP_W'(cfg_mask_i[j]);
    end
    fifo_free = CMP_W'(CNT_W'(DEPTH) - fill_q);

    // Current entry is last when no higher latched mask bit remains.
    higher_set = 1'b0;
    for (int unsigned j = 0; j < 8; j++) begin
      if ((j > 32'(idx_q)) && mask_q[j]) begin
        higher_set = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!cfg_enable_i) begin
          count_d = '0;
        end else if (count_q == cfg_period_i) begin
          count_d = '0;
          if (|cfg_mask_i) begin
            if (fifo_free < mask_pop) begin
              drop = 1'b1;
            end else begin
              state_d = ST_SCAN;
              idx_d   = '0;
              mask_d  = 8'(cfg_mask_i);
            end
          end
        end else begin
          count_d = PERIOD_WIDTH'(count_q + 1'b1);
        end
      end
      ST_SCAN: begin
        count_d = '0;
        if (!mask_q[idx_q]) begin
          advance = 1'b1;
        end else if (!cpu_spr_access_i) begin
          samp_access = 1'b1;
          if (pcu_spr_bus_ack_i) begin
            push    = 1'b1;
            advance = 1'b1;
          end
        end
        if (advance) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = 3'(idx_q + 1'b1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end
    done_d = push & ~higher_set;

    pop = fifo_valid & snap_if.snap_ready;
    if (push) begin
      wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    case ({push, pop})
      2'b10:   fill_d = CNT_W'(fill_q + 1'b1);
      2'b01:   fill_d = CNT_W'(fill_q - 1'b1);
      default: fill_d = fill_q;
    endcase

    // CPU wins the port; the sampler only ever issues reads.
    if (cpu_spr_access_i) begin
      pcu_spr_access_o = 1'b1;
      pcu_spr_we_o     = cpu_spr_we_i;
      pcu_spr_re_o     = cpu_spr_re_i;
      pcu_spr_addr_o   = cpu_spr_addr_i;
      pcu_spr_dat_o    = cpu_spr_dat_i;
    end else begin
      pcu_spr_access_o = samp_access;
      pcu_spr_we_o     = 1'b0;
      pcu_spr_re_o     = samp_access;
      pcu_spr_addr_o   = samp_access ? 16'(PCCR0_ADDR + 16'(idx_q)) : 16'h0000;
      pcu_spr_dat_o    = 32'h0000_0000;
    end
  end

  assign cpu_spr_bus_ack_o = cpu_spr_access_i & pcu_spr_bus_ack_i;
  assign cpu_spr_dat_o     = pcu_spr_dat_i;

  // FWFT head, forced to zero while the FIFO is empty.
  assign fifo_valid         = (fill_q != '0);
  assign head               = mem_q[rd_ptr_q];
  assign snap_if.snap_valid = fifo_valid;
  assign snap_if.snap_data  = fifo_valid ? head[31:0]  : 32'h0000_0000;
  assign snap_if.snap_last  = fifo_valid ? head[32]    : 1'b0;
  assign snap_if.snap_idx   = fifo_valid ? head[35:33] : 3'd0;

  assign sample_done_o = done_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mor1kx_pcu_sampler.sv
module tb_mor1kx_pcu_sampler;

  localparam int W_DONE  = 0;
  localparam int W_BUSY  = 1;
  localparam int W_OVF   = 2;
  localparam int W_DRAIN = 3;
  localparam int W_VALID = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_spr_access_i, cpu_spr_we_i, cpu_spr_re_i;
  logic [15:0] cpu_spr_addr_i;
  logic [31:0] cpu_spr_dat_i;
  logic        cpu_spr_bus_ack_o;
  logic [31:0] cpu_spr_dat_o;
  logic        pcu_spr_access_o, pcu_spr_we_o, pcu_spr_re_o;
  logic [15:0] pcu_spr_addr_o;
  logic [31:0] pcu_spr_dat_o;
  logic        pcu_spr_bus_ack_i;
  logic [31:0] pcu_spr_dat_i;
  logic        cfg_enable_i;
  logic [15:0] cfg_period_i;
  logic [7:0]  cfg_mask_i;
  logic        sample_done_o, overflow_o, overflow_clr_i, busy_o;

  mor1kx_pcu_sampler_if snap_if();

  always #5 clk = ~clk;

  mor1kx_pcu_sampler dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_spr_access_i  (cpu_spr_access_i),
    .cpu_spr_we_i      (cpu_spr_we_i),
    .cpu_spr_re_i      (cpu_spr_re_i),
    .cpu_spr_addr_i    (cpu_spr_addr_i),
    .cpu_spr_dat_i     (cpu_spr_dat_i),
    .cpu_spr_bus_ack_o (cpu_spr_bus_ack_o),
    .cpu_spr_dat_o     (cpu_spr_dat_o),
    .pcu_spr_access_o  (pcu_spr_access_o),
    .pcu_spr_we_o      (pcu_spr_we_o),
    .pcu_spr_re_o      (pcu_spr_re_o),
    .pcu_spr_addr_o    (pcu_spr_addr_o),
    .pcu_spr_dat_o     (pcu_spr_dat_o),
    .pcu_spr_bus_ack_i (pcu_spr_bus_ack_i),
    .pcu_spr_dat_i     (pcu_spr_dat_i),
    .cfg_enable_i      (cfg_enable_i),
    .cfg_period_i      (cfg_period_i),
    .cfg_mask_i        (cfg_mask_i),
    .snap_if           (snap_if),
    .sample_done_o     (sample_done_o),
    .overflow_o        (overflow_o),
    .overflow_clr_i    (overflow_clr_i),
    .busy_o            (busy_o)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic        last;
    logic [31:0] data;
  } snap_t;

  snap_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  int    cycle = 0;
  int    done_cyc[$];
  int    wr_viol = 0;
  int    rd_cnt [8] = '{default: 0};
  int    exp_cnt[8] = '{default: 0};
  snap_t got_e, exp_e;

  function automatic logic [31:0] pccr_base(input int i);
    return 32'hA000_0000 | (32'(i) << 20);
  endfunction

  // PCU model: PCCRn at 0x3800+n, each read returns the next count value.
  logic in_range;
  assign in_range          = (pcu_spr_addr_o[15:3] == 13'h0700);
  assign pcu_spr_bus_ack_i = pcu_spr_access_o;
  assign pcu_spr_dat_i     = in_range ?
      (pccr_base(int'(pcu_spr_addr_o[2:0])) + 32'(rd_cnt[pcu_spr_addr_o[2:0]])) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (pcu_spr_access_o && pcu_spr_re_o && in_range)
      rd_cnt[pcu_spr_addr_o[2:0]] <= rd_cnt[pcu_spr_addr_o[2:0]] + 1;
  end

  // Stream scoreboard and event monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (snap_if.snap_valid && snap_if.snap_ready) begin
        total++;
        got_e = {snap_if.snap_idx, snap_if.snap_last, snap_if.snap_data};
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL snap_unexpected: got idx=%0d last=%0b data=%h, required no entry",
                   got_e.idx, got_e.last, got_e.data);
        end else begin
          exp_e = sb.pop_front();
          if (got_e !== exp_e) begin
            bad++;
            $display("FAIL snap_entry: got idx=%0d last=%0b data=%h, required idx=%0d last=%0b data=%h",
                     got_e.idx, got_e.last, got_e.data, exp_e.idx, exp_e.last, exp_e.data);
          end
        end
      end
      if (sample_done_o) begin
        done_cnt++;
        done_cyc.push_back(cycle);
      end
      if (!cpu_spr_access_i && pcu_spr_we_o) wr_viol++;
    end
  end

  task automatic push_sample(input logic [7:0] m);
    snap_t e;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.idx  = 3'(i);
        e.last = ((m >> (i + 1)) == 8'h00);
        e.data = pccr_base(i) + 32'(exp_cnt[i]);
        exp_cnt[i]++;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_for(input int kind, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      case (kind)
        W_DONE:  ok = (done_cnt >= target);
        W_BUSY:  ok = (busy_o === 1'b1);
        W_OVF:   ok = (overflow_o === 1'b1);
        W_DRAIN: ok = (sb.size() == 0);
        default: ok = (snap_if.snap_valid === 1'b1);
      endcase
      if (ok) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_spr_access_i = 1'b0; cpu_spr_we_i = 1'b0; cpu_spr_re_i = 1'b0;
    cpu_spr_addr_i = 16'h0; cpu_spr_dat_i = 32'h0;
    cfg_enable_i = 1'b0; cfg_period_i = 16'd0; cfg_mask_i = 8'h00;
    overflow_clr_i = 1'b0; snap_if.snap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({snap_if.snap_valid, busy_o, overflow_o, sample_done_o, pcu_spr_access_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_status: got valid/busy/ovf/done/acc=%b, required 00000",
               {snap_if.snap_valid, busy_o, overflow_o, sample_done_o, pcu_spr_access_o});
    end
    total++;
    if ({snap_if.snap_data, snap_if.snap_idx, snap_if.snap_last} !== 36'h0) begin
      bad++;
      $display("FAIL reset_head: got %h, required 0",
               {snap_if.snap_data, snap_if.snap_idx, snap_if.snap_last});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_spr_access_i = 1'b1; cpu_spr_re_i = 1'b1; cpu_spr_addr_i = 16'h1234;
    #1;
    total++;
    if ({cpu_spr_bus_ack_o, pcu_spr_access_o, pcu_spr_re_o, pcu_spr_addr_o, cpu_spr_dat_o} !==
        {3'b111, 16'h1234, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL passthrough: got ack=%b acc=%b re=%b addr=%h dat=%h, required 1 1 1 1234 deadbeef",
               cpu_spr_bus_ack_o, pcu_spr_access_o, pcu_spr_re_o, pcu_spr_addr_o, cpu_spr_dat_o);
    end
    @(posedge clk); #1;
    cpu_spr_access_i = 1'b0; cpu_spr_re_i = 1'b0; cpu_spr_addr_i = 16'h0;
  endtask

  task automatic test_periodic;
    bit ok;
    int base;
    cfg_period_i = 16'd3; cfg_mask_i = 8'h05; snap_if.snap_ready = 1'b1;
    repeat (3) push_sample(8'h05);
    base = done_cnt;
    done_cyc.delete();
    cfg_enable_i = 1'b1;
    wait_for(W_DONE, base + 3, 200, ok);
    cfg_enable_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL periodic_done_timeout: got %0d dones, required 3", done_cnt - base); end
    wait_for(W_DRAIN, 0, 50, ok);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (!ok || snap_if.snap_valid !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL periodic_drain: got pending=%0d valid=%b busy=%b, required 0 0 0",
               sb.size(), snap_if.snap_valid, busy_o);
    end
    total++;
    if (done_cyc.size() != 3 || (done_cyc[1] - done_cyc[0]) != 12 || (done_cyc[2] - done_cyc[1]) != 12) begin
      bad++;
      $display("FAIL periodic_interval: got %0d pulses, required 3 pulses 12 cycles apart", done_cyc.size());
    end
  endtask

  task automatic test_cpu_contention;
    bit ok;
    int base;
    cfg_period_i = 16'd0; cfg_mask_i = 8'h0F; snap_if.snap_ready = 1'b1;
    push_sample(8'h0F);
    base = done_cnt;
    cfg_enable_i = 1'b1;
    wait_for(W_BUSY, 0, 20, ok);
    cfg_enable_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL contention_busy_timeout: got busy=%b, required 1", busy_o); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      cpu_spr_access_i = 1'b1; cpu_spr_we_i = 1'b1; cpu_spr_re_i = 1'b0;
      cpu_spr_addr_i = 16'h3808; cpu_spr_dat_i = 32'h5500_0000 + 32'(k);
      #1;
      total++;
      if (cpu_spr_bus_ack_o !== 1'b1) begin
        bad++; $display("FAIL contention_ack[%0d]: got %b, required 1", k, cpu_spr_bus_ack_o);
      end
      total++;
      if ({pcu_spr_we_o, pcu_spr_re_o, pcu_spr_addr_o, pcu_spr_dat_o} !==
          {2'b10, 16'h3808, 32'h5500_0000 + 32'(k)}) begin
        bad++;
        $display("FAIL contention_mux[%0d]: got we=%b re=%b addr=%h dat=%h, required 1 0 3808 %h",
                 k, pcu_spr_we_o, pcu_spr_re_o, pcu_spr_addr_o, pcu_spr_dat_o, 32'h5500_0000 + 32'(k));
      end
    end
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL contention_stall: got busy=%b, required 1", busy_o); end
    @(posedge clk); #1;
    cpu_spr_access_i = 1'b0; cpu_spr_we_i = 1'b0; cpu_spr_addr_i = 16'h0; cpu_spr_dat_i = 32'h0;
    wait_for(W_DONE, base + 1, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL contention_done_timeout: got %0d, required 1", done_cnt - base); end
    wait_for(W_DRAIN, 0, 40, ok);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (!ok || snap_if.snap_valid !== 1'b0 || done_cnt != base + 1) begin
      bad++;
      $display("FAIL contention_drain: got pending=%0d valid=%b dones=%0d, required 0 0 1",
               sb.size(), snap_if.snap_valid, done_cnt - base);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    int base;
    cfg_period_i = 16'd0; cfg_mask_i = 8'hFF; snap_if.snap_ready = 1'b0;
    repeat (2) push_sample(8'hFF);
    base = done_cnt;
    cfg_enable_i = 1'b1;
    wait_for(W_OVF, 0, 100, ok);
    cfg_enable_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL overflow_timeout: got ovf=%b, required 1", overflow_o); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt - base != 2 || snap_if.snap_valid !== 1'b1 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_hold: got dones=%0d valid=%b ovf=%b, required 2 1 1",
               done_cnt - base, snap_if.snap_valid, overflow_o);
    end
    overflow_clr_i = 1'b1;
    @(posedge clk); #1;
    overflow_clr_i = 1'b0;
    total++;
    if (overflow_o !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b, required 0", overflow_o); end
    snap_if.snap_ready = 1'b1;
    wait_for(W_DRAIN, 0, 60, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || snap_if.snap_valid !== 1'b0) begin
      bad++;
      $display("FAIL overflow_drain: got pending=%0d valid=%b, required 0 0", sb.size(), snap_if.snap_valid);
    end
    // Refill, then hold clear while drops keep occurring every cycle.
    snap_if.snap_ready = 1'b0;
    repeat (2) push_sample(8'hFF);
    base = done_cnt;
    cfg_enable_i = 1'b1;
    wait_for(W_DONE, base + 2, 100, ok);
    overflow_clr_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (!ok || overflow_o !== 1'b1) begin
      bad++; $display("FAIL overflow_set_wins: got ovf=%b, required 1", overflow_o);
    end
    cfg_enable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    overflow_clr_i = 1'b0;
    total++;
    if (overflow_o !== 1'b0) begin bad++; $display("FAIL overflow_clear2: got %b, required 0", overflow_o); end
    snap_if.snap_ready = 1'b1;
    wait_for(W_DRAIN, 0, 60, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || snap_if.snap_valid !== 1'b0 || done_cnt - base != 2) begin
      bad++;
      $display("FAIL overflow_drain2: got pending=%0d valid=%b dones=%0d, required 0 0 2",
               sb.size(), snap_if.snap_valid, done_cnt - base);
    end
  endtask

  task automatic test_mask_zero;
    int activity;
    int base;
    activity = 0;
    base = done_cnt;
    cfg_period_i = 16'd0; cfg_mask_i = 8'h00; snap_if.snap_ready = 1'b1;
    cfg_enable_i = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (pcu_spr_access_o || busy_o || snap_if.snap_valid) activity++;
    end
    cfg_enable_i = 1'b0;
    total++;
    if (activity != 0 || done_cnt != base) begin
      bad++;
      $display("FAIL mask_zero: got active_cycles=%0d dones=%0d, required 0 0", activity, done_cnt - base);
    end
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    cfg_period_i = 16'd0; cfg_mask_i = 8'hFF; snap_if.snap_ready = 1'b0;
    cfg_enable_i = 1'b1;
    wait_for(W_VALID, 0, 20, ok);
    total++;
    if (!ok || busy_o !== 1'b1) begin
      bad++; $display("FAIL midscan_setup: got valid=%b busy=%b, required 1 1", snap_if.snap_valid, busy_o);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({snap_if.snap_valid, snap_if.snap_last, snap_if.snap_idx, snap_if.snap_data,
         busy_o, sample_done_o, overflow_o, pcu_spr_access_o, pcu_spr_re_o} !== 43'h0) begin
      bad++;
      $display("FAIL midscan_reset: got valid=%b data=%h idx=%0d busy=%b acc=%b, required all 0",
               snap_if.snap_valid, snap_if.snap_data, snap_if.snap_idx, busy_o, pcu_spr_access_o);
    end
    sb.delete();
    cfg_enable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (snap_if.snap_valid !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL midscan_after: got valid=%b busy=%b, required 0 0", snap_if.snap_valid, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_cpu_contention();
    test_overflow();
    test_mask_zero();
    test_reset_mid_scan();
    total++;
    if (wr_viol != 0) begin
      bad++; $display("FAIL sampler_write: got %0d sampler write cycles, required 0", wr_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
